riscv_id_stage: RTL

Instruction-decode stage of the RV32I pipeline, sitting between instruction fetch and execute. It accepts one fetched instruction per cycle and drives the two read ports of the 1-cycle-latency register file. It extracts fields and the sign-extended immediate, and presents decoded instruction plus both source operands to execute over a valid/ready handshake. Operand values are kept coherent with register-file writes through bypass and in-stage operand tracking.

---
 rtl/riscv_id_stage_if.sv | 57 +++++
 rtl/riscv_id_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/riscv_id_stage_if.sv
// Fetch, register-file, write-back and execute signals of the RV32I decode stage.
// slave is the decode-stage view; master is the surrounding pipeline's view.
interface riscv_id_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           in_instr;
   logic [DATA_WIDTH-1:0] in_pc;
   logic                  flush;

   logic [ADDR_WIDTH-1:0] rf_rd1_addr;
   logic [ADDR_WIDTH-1:0] rf_rd2_addr;
   logic                  rf_rd1_en;
   logic                  rf_rd2_en;
   logic [DATA_WIDTH-1:0] rf_rd1_data;
   logic [DATA_WIDTH-1:0] rf_rd2_data;

   logic                  wb_en;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [DATA_WIDTH-1:0] wb_data;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_pc;
   logic [6:0]            out_opcode;
   logic [4:0]            out_rd;
   logic [2:0]            out_funct3;
   logic [6:0]            out_funct7;
   logic [DATA_WIDTH-1:0] out_rs1_data;
   logic [DATA_WIDTH-1:0] out_rs2_data;
   logic [DATA_WIDTH-1:0] out_imm;
   logic                  out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, flush,
      input  rf_rd1_data, rf_rd2_data,
      input  wb_en, wb_addr, wb_data,
      input  out_ready,
      output in_ready,
      output rf_rd1_addr, rf_rd2_addr, rf_rd1_en, rf_rd2_en,
      output out_valid, out_pc, out_opcode, out_rd, out_funct3, out_funct7,
      output out_rs1_data, out_rs2_data, out_imm, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, flush,
      output rf_rd1_data, rf_rd2_data,
      output wb_en, wb_addr, wb_data,
      output out_ready,
      input  in_ready,
      input  rf_rd1_addr, rf_rd2_addr, rf_rd1_en, rf_rd2_en,
      input  out_valid, out_pc, out_opcode, out_rd, out_funct3, out_funct7,
      input  out_rs1_data, out_rs2_data, out_imm, out_illegal
   );
endinterface

// File: rtl/riscv_id_stage.sv
// RV32I decode stage, single slot: accept at edge N gives out_valid in cycle N+1 (1/cycle throughput).
// Backpressure: in_ready drops while the slot is held (out_ready low) or flush is high.
module riscv_id_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   riscv_id_stage_if.slave bus
);
   typedef enum logic {ST_FRESH, ST_HELD} opnd_state_t;
   opnd_state_t r_state, w_state_nxt;

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_imm;
   logic [6:0]            r_opcode;
   logic [6:0]            r_funct7;
   logic [4:0]            r_rd;
   logic [2:0]            r_funct3;
   logic                  r_illegal;
   logic [ADDR_WIDTH-1:0] r_rs      [2];
   logic                  r_fwd     [2];
   logic [DATA_WIDTH-1:0] r_fwd_val [2];
   logic [DATA_WIDTH-1:0] r_op      [2];

   logic                  w_accept;
   logic                  w_xfer;
   logic [31:0]           w_ins;
   logic [31:0]           w_imm32;
   logic                  w_illegal;
   logic [ADDR_WIDTH-1:0] w_rs_in   [2];
   logic [DATA_WIDTH-1:0] w_rf_data [2];
   logic [DATA_WIDTH-1:0] w_opnd    [2];

   assign w_ins        = bus.in_instr;
   assign w_rs_in[0]   = ADDR_WIDTH'(w_ins[19:15]);
   assign w_rs_in[1]   = ADDR_WIDTH'(w_ins[24:20]);
   assign w_rf_data[0] = bus.rf_rd1_data;
   assign w_rf_data[1] = bus.rf_rd2_data;

   assign bus.in_ready    = !bus.flush && (!r_valid || bus.out_ready);
   assign w_accept        = bus.in_valid && bus.in_ready;
   assign w_xfer          = r_valid && bus.out_ready;
   assign bus.rf_rd1_addr = w_rs_in[0];
   assign bus.rf_rd2_addr = w_rs_in[1];
   assign bus.rf_rd1_en   = w_accept && rst_n;
   assign bus.rf_rd2_en   = w_accept && rst_n;

   always_comb begin
      w_imm32   = '0;
      w_illegal = 1'b0;
      case (w_ins[6:0])
         7'b0000011, 7'b0010011, 7'b1100111:
            w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
         7'b0100011:
            w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
         7'b1100011:
            w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
         7'b0110111, 7'b0010111:
            w_imm32 = {w_ins[31:12], 12'b0};
         7'b1101111:
            w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
         7'b0110011, 7'b0001111, 7'b1110011:
            w_imm32 = '0;
         default:
            w_illegal = 1'b1;
      endcase
   end

   // FRESH: register file (or the write captured in the accept cycle) is current.
   // HELD: the local copy is current; a write this cycle always overrides.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         w_opnd[k] = (r_state == ST_FRESH) ? (r_fwd[k] ? r_fwd_val[k] : w_rf_data[k]) : r_op[k];
         if (bus.wb_en && bus.wb_addr == r_rs[k])
            w_opnd[k] = bus.wb_data;
         if (!r_valid || r_rs[k] == '0)
            w_opnd[k] = '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept)
         w_state_nxt = ST_FRESH;
      else if (r_valid)
         w_state_nxt = ST_HELD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_FRESH;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_imm     <= '0;
         r_opcode  <= '0;
         r_funct7  <= '0;
         r_rd      <= '0;
         r_funct3  <= '0;
         r_illegal <= 1'b0;
         for (int k = 0; k < 2; k++) begin
            r_rs[k]      <= '0;
            r_fwd[k]     <= 1'b0;
            r_fwd_val[k] <= '0;
            r_op[k]      <= '0;
         end
      end else begin
         if (bus.flush)
            r_valid <= 1'b0;
         else if (w_accept)
            r_valid <= 1'b1;
         else if (w_xfer)
            r_valid <= 1'b0;

         if (w_accept) begin
            r_pc      <= bus.in_pc;
            r_imm     <= DATA_WIDTH'($signed(w_imm32));
            r_opcode  <= w_ins[6:0];
            r_rd      <= w_ins[11:7];
            r_funct3  <= w_ins[14:12];
            r_funct7  <= w_ins[31:25];
            r_illegal <= w_illegal;
         end

         for (int k = 0; k < 2; k++) begin
            if (w_accept) begin
               r_rs[k]      <= w_rs_in[k];
               // The register file returns the pre-write value when it is written during the read.
               r_fwd[k]     <= bus.wb_en && bus.wb_addr == w_rs_in[k] && w_rs_in[k] != '0;
               r_fwd_val[k] <= bus.wb_data;
            end
            if (r_valid)
               r_op[k] <= w_opnd[k];
         end
      end
   end

   assign bus.out_valid    = r_valid;
   assign bus.out_pc       = r_pc;
   assign bus.out_opcode   = r_opcode;
   assign bus.out_rd       = r_rd;
   assign bus.out_funct3   = r_funct3;
   assign bus.out_funct7   = r_funct7;
   assign bus.out_imm      = r_imm;
   assign bus.out_illegal  = r_illegal;
   assign bus.out_rs1_data = w_opnd[0];
   assign bus.out_rs2_data = w_opnd[1];
endmodule
